// File: rtl/conv1_frame_ctrl_pkg.sv
// conv1_frame_ctrl_pkg: shared state encoding, sizing helpers and constants
// for the conv1 frame sequencer.
package conv1_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int W_ADDR_W = 5;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A pixel closes a full kernel window once both coordinates reach KERNEL_W-1.
  function automatic logic in_window(input int x, input int y, input int k);
    return (x >= k - 1) && (y >= k - 1);
  endfunction

endpackage

// File: rtl/conv1_frame_ctrl_if.sv
// conv1_frame_if: pixel stream, engine feed and weight-load signals of the
// conv1 sequencer. master = controller side, slave = pixel source / engine / ROM.
interface conv1_frame_if #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 16
);
  logic [PIX_W-1:0]        pix_in_data;
  logic                    pix_in_valid;
  logic                    pix_in_ready;
  logic [PIX_W-1:0]        eng_data;
  logic                    eng_data_valid;
  logic                    eng_img_en;
  logic [4:0]              w_rom_addr;
  logic signed [WGT_W-1:0] w_rom_data;
  logic                    w_load_en;
  logic [4:0]              w_load_idx;
  logic signed [WGT_W-1:0] w_load_data;
  logic                    eng_out_valid;

  modport master (
    input  pix_in_data, pix_in_valid, w_rom_data,
    output pix_in_ready, eng_data, eng_data_valid, eng_img_en,
           w_rom_addr, w_load_en, w_load_idx, w_load_data, eng_out_valid
  );

  modport slave (
    output pix_in_data, pix_in_valid, w_rom_data,
    input  pix_in_ready, eng_data, eng_data_valid, eng_img_en,
           w_rom_addr, w_load_en, w_load_idx, w_load_data, eng_out_valid
  );
endinterface

// File: rtl/conv1_frame_ctrl_pos_counter.sv
// conv1_pos_counter: x/y pixel position inside the frame. Advances on en,
// x wraps at IMG_W and carries into y; y wraps at IMG_H. last flags the final pixel.
module conv1_pos_counter
  import conv1_frame_ctrl_pkg::*;
#(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int XW    = cnt_w(IMG_W),
  parameter int YW    = cnt_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          last
);

  // Raster-order position update; clr has priority over en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (clr) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (en) begin
      if (x_cnt == XW'(IMG_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == YW'(IMG_H - 1)) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  assign last = (x_cnt == XW'(IMG_W - 1)) && (y_cnt == YW'(IMG_H - 1));

endmodule

// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl: sequencer for the conv1 5x5 engine. Loads KERNEL_W^2
// weights from the ROM, streams one IMG_W x IMG_H frame with valid/ready,
// flags valid engine sums and pulses done after draining the pipeline.
// Optional build macro CONV1_CTRL_STALL_CNT_EN adds stall_cnt, the number of
// STREAM cycles without an incoming pixel.
module conv1_frame_ctrl
  import conv1_frame_ctrl_pkg::*;
#(
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 200,
  parameter int KERNEL_W = 5,
  parameter int PIPE_LAT = 2,
  parameter int PIX_W    = 8,
  parameter int WGT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  conv1_frame_if.master   bus
`ifdef CONV1_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int N_WGT = KERNEL_W * KERNEL_W;
  localparam int XW    = cnt_w(IMG_W);
  localparam int YW    = cnt_w(IMG_H);
  localparam int DRN_W = cnt_w(PIPE_LAT + 1);

  state_t                  state;
  logic [W_ADDR_W-1:0]     k_cnt;
  logic [DRN_W-1:0]        drn_cnt;
  logic                    pix_rdy;
  logic                    img_en;
  logic                    wld_en;
  logic                    accept;
  logic                    start_go;
  logic                    abort_go;
  logic                    pos_clr;
  logic                    pos_last;
  logic [XW-1:0]           x_cnt;
  logic [YW-1:0]           y_cnt;
  logic                    win;
  logic signed [WGT_W-1:0] wgt_p0;
  logic [PIX_W-1:0]        eng_data_p1;
  logic                    vld_p1;
  logic [PIPE_LAT:0]       vld_p;

  assign accept   = bus.pix_in_valid & pix_rdy;
  assign start_go = (state == ST_IDLE) & start & ~abort;
  assign abort_go = abort & ((state == ST_LOAD_W) | (state == ST_STREAM) | (state == ST_DRAIN));
  assign pos_clr  = abort | (state == ST_IDLE);
  assign win      = accept & in_window(int'(x_cnt), int'(y_cnt), KERNEL_W);

  conv1_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .clr   (pos_clr),
    .en    (accept),
    .x_cnt (x_cnt),
    .y_cnt (y_cnt),
    .last  (pos_last)
  );

  // Frame FSM with registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pix_rdy <= 1'b0;
      img_en  <= 1'b0;
      wld_en  <= 1'b0;
      k_cnt   <= '0;
      drn_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort_go) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        pix_rdy <= 1'b0;
        img_en  <= 1'b0;
        wld_en  <= 1'b0;
        k_cnt   <= '0;
        drn_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_go) begin
              state  <= ST_LOAD_W;
              busy   <= 1'b1;
              wld_en <= 1'b1;
              k_cnt  <= '0;
            end
          end
          ST_LOAD_W: begin
            if (k_cnt == W_ADDR_W'(N_WGT - 1)) begin
              state   <= ST_STREAM;
              wld_en  <= 1'b0;
              k_cnt   <= '0;
              pix_rdy <= 1'b1;
              img_en  <= 1'b1;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
          ST_STREAM: begin
            if (accept && pos_last) begin
              state   <= ST_DRAIN;
              pix_rdy <= 1'b0;
              img_en  <= 1'b0;
              drn_cnt <= '0;
            end
          end
          ST_DRAIN: begin
            if (drn_cnt == DRN_W'(PIPE_LAT)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              drn_cnt <= drn_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage p1: accepted pixel registered toward the engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) eng_data_p1 <= bus.pix_in_data;
    end
  end

  // Window-valid delay line; keeps shifting outside STREAM so late sums still flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= win;
      for (int i = 1; i <= PIPE_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

`ifdef CONV1_CTRL_STALL_CNT_EN
  // Bubble counter: STREAM cycles with no pixel offered, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_go) begin
      stall_cnt <= '0;
    end else if ((state == ST_STREAM) && !bus.pix_in_valid) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign wgt_p0             = bus.w_rom_data;
  assign bus.pix_in_ready   = pix_rdy;
  assign bus.eng_img_en     = img_en;
  assign bus.eng_data       = eng_data_p1;
  assign bus.eng_data_valid = vld_p1;
  assign bus.w_rom_addr     = k_cnt;
  assign bus.w_load_en      = wld_en;
  assign bus.w_load_idx     = wld_en ? k_cnt : '0;
  assign bus.w_load_data    = wld_en ? wgt_p0 : '0;
  assign bus.eng_out_valid  = vld_p[PIPE_LAT];

endmodule
